// File: rtl/ysyx_25040129_rtc_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ysyx_25040129_rtc_slave_if
//  Description : AXI4-Lite read/write channel bundle between the XBAR rtc_*
//                port (master) and the RTC timer endpoint (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_25040129_rtc_slave_if;
    // Read address / read data channels
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    // Write address / write data / write response channels
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_25040129_rtc_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ysyx_25040129_rtc_slave
//  Description : Read-only AXI4-Lite timer endpoint. Free-running 64-bit mtime
//                advanced by a clock prescaler; read as two 32-bit words with
//                the high half snapshotted on the low-word read; writes are
//                accepted and answered with SLVERR.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040129_rtc_slave #(
    parameter logic [31:0] BASE_ADDR = 32'ha000_0048,
    parameter int          CLK_DIV   = 1
) (
    input  wire logic                    clk,
    input  wire logic                    rst,   // asynchronous, active-low
    ysyx_25040129_rtc_slave_if.slave     bus
);

    localparam int          c_PRESC_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [1:0]  c_RESP_OK  = 2'b00;
    localparam logic [1:0]  c_RESP_ERR = 2'b10;

    // Read FSM: bit0 = arready, bit1 = rvalid, so handshake outputs are flops.
    localparam logic [1:0]  c_R_INIT   = 2'b00;
    localparam logic [1:0]  c_R_IDLE   = 2'b01;
    localparam logic [1:0]  c_R_RESP   = 2'b10;

    // Write FSM: bit0 = awready, bit1 = wready, bit2 = bvalid.
    localparam logic [2:0]  c_W_INIT   = 3'b000;
    localparam logic [2:0]  c_W_IDLE   = 3'b011;
    localparam logic [2:0]  c_W_GOT_AW = 3'b010;
    localparam logic [2:0]  c_W_GOT_W  = 3'b001;
    localparam logic [2:0]  c_W_RESP   = 3'b100;

    logic [c_PRESC_W-1:0] r_presc;
    logic [63:0]          r_mtime;
    logic [31:0]          r_hi_snap;
    logic [31:0]          r_rdata;
    logic [1:0]           r_rresp;
    logic [1:0]           r_rstate;
    logic [1:0]           w_rnext;
    logic [2:0]           r_wstate;
    logic [2:0]           w_wnext;

    logic                 w_tick;
    logic                 w_ar_hs;
    logic [31:0]          w_off;
    logic                 w_arready;
    logic                 w_rvalid;
    logic                 w_awready;
    logic                 w_wready;
    logic                 w_bvalid;
    logic [1:0]           w_bresp;
    logic                 w_unused;

    // Write payload only completes the handshake; it never reaches any state.
    assign w_unused = ^{bus.awaddr, bus.wdata, bus.wstrb};

    assign w_tick  = (r_presc == c_PRESC_W'(CLK_DIV - 1));
    assign w_ar_hs = (r_rstate == c_R_IDLE) && bus.arvalid;
    assign w_off   = bus.araddr - BASE_ADDR;

    // Prescaler and 64-bit time base, free-running regardless of bus activity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_mtime <= '0;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
                r_mtime <= r_mtime + 64'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate <= c_R_INIT;
        end else begin
            r_rstate <= w_rnext;
        end
    end

    // Read FSM next-state: one outstanding read, AR blocked while responding.
    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            c_R_INIT: w_rnext = c_R_IDLE;
            c_R_IDLE: if (bus.arvalid) w_rnext = c_R_RESP;
            c_R_RESP: if (bus.rready)  w_rnext = c_R_IDLE;
            default:  w_rnext = c_R_IDLE;
        endcase
    end

    // Read FSM outputs taken straight from the state flops.
    always_comb begin
        w_arready = r_rstate[0];
        w_rvalid  = r_rstate[1];
    end

    // Read data capture; the low-word read latches the matching high half
    // on the same edge so a following high-word read is coherent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata   <= '0;
            r_rresp   <= c_RESP_OK;
            r_hi_snap <= '0;
        end else if (w_ar_hs) begin
            if (w_off == 32'd0) begin
                r_rdata   <= r_mtime[31:0];
                r_rresp   <= c_RESP_OK;
                r_hi_snap <= r_mtime[63:32];
            end else if (w_off == 32'd4) begin
                r_rdata   <= r_hi_snap;
                r_rresp   <= c_RESP_OK;
            end else begin
                r_rdata   <= '0;
                r_rresp   <= c_RESP_ERR;
            end
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate <= c_W_INIT;
        end else begin
            r_wstate <= w_wnext;
        end
    end

    // Write FSM next-state: AW and W accepted independently, response once both seen.
    always_comb begin
        w_wnext = r_wstate;
        case (r_wstate)
            c_W_INIT: w_wnext = c_W_IDLE;
            c_W_IDLE: begin
                if (bus.awvalid && bus.wvalid) begin
                    w_wnext = c_W_RESP;
                end else if (bus.awvalid) begin
                    w_wnext = c_W_GOT_AW;
                end else if (bus.wvalid) begin
                    w_wnext = c_W_GOT_W;
                end
            end
            c_W_GOT_AW: if (bus.wvalid)  w_wnext = c_W_RESP;
            c_W_GOT_W:  if (bus.awvalid) w_wnext = c_W_RESP;
            c_W_RESP:   if (bus.bready)  w_wnext = c_W_IDLE;
            default:    w_wnext = c_W_IDLE;
        endcase
    end

    // Write FSM outputs taken straight from the state flops; bresp is SLVERR whenever valid.
    always_comb begin
        w_awready = r_wstate[0];
        w_wready  = r_wstate[1];
        w_bvalid  = r_wstate[2];
        w_bresp   = {r_wstate[2], 1'b0};
    end

    assign bus.arready = w_arready;
    assign bus.rvalid  = w_rvalid;
    assign bus.rdata   = r_rdata;
    assign bus.rresp   = r_rresp;
    assign bus.awready = w_awready;
    assign bus.wready  = w_wready;
    assign bus.bvalid  = w_bvalid;
    assign bus.bresp   = w_bresp;

endmodule
`default_nettype wire
